key_debounce_n: RTL and testbench
=================================

KEY_DEBOUNCE_N -- requirements
Module: key_debounce_n

Interface
REQ-001 The block SHALL have parameter P_SYSTEM_CLK, default 100_000_000, meaning the clock frequency in Hz.
REQ-002 The block SHALL have parameter P_KEY_NUM, default 4, meaning the number of independent key channels (1..16).
REQ-003 The block SHALL have parameter P_TICK_CYCLES, default P_SYSTEM_CLK/1000, meaning clk cycles per 1 ms tick; it is overridable for simulation.
REQ-004 The block SHALL have parameter P_DEBOUNCE_MS, default 20, meaning the stable-time requirement in ticks (>=1).
REQ-005 The block SHALL have parameter P_LONG_MS, default 1000, meaning the hold time in ticks for a long-press event; 0 disables long-press.
REQ-006 The block SHALL have parameter P_ACTIVE_LOW, default 1, meaning 1 = key pressed when the pin is 0.
REQ-007 clk  input  1  the single system clock; all logic is on its rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 i_key  input  P_KEY_NUM  raw asynchronous key pins.
REQ-010 o_key  output  P_KEY_NUM  debounced level per channel, 1 = pressed.
REQ-011 o_press  output  P_KEY_NUM  one-cycle pulse per channel on debounced press.
REQ-012 o_release  output  P_KEY_NUM  one-cycle pulse per channel on debounced release.
REQ-013 o_long  output  P_KEY_NUM  one-cycle pulse per channel when the hold reaches P_LONG_MS.
REQ-014 o_key_val  output  1  one-cycle pulse, the OR of all o_press, o_release and o_long bits in the same cycle.

Function
REQ-015 Each pin SHALL be normalised (inverted when P_ACTIVE_LOW=1) and passed through a 2-flop synchroniser before any decision logic.
REQ-016 One shared tick counter SHALL count 0..P_TICK_CYCLES-1 and assert tick for exactly one cycle at the terminal count, then wrap to 0.
REQ-017 Each channel SHALL run an independent FSM with states S_UP, S_DEB_DN, S_DOWN, S_DEB_UP.
REQ-018 In S_UP, a synchronised pressed level SHALL move to S_DEB_DN and clear the debounce count.
REQ-019 In S_DEB_DN, a synchronised released level SHALL return to S_UP with no event; otherwise each tick increments the count; a tick at count P_DEBOUNCE_MS-1 SHALL enter S_DOWN, set o_key, pulse o_press and clear the hold count.
REQ-020 In S_DOWN, the hold count SHALL increment on each tick and saturate at P_LONG_MS; o_long SHALL pulse on the cycle it reaches P_LONG_MS, at most once per press; a released level SHALL move to S_DEB_UP and clear the debounce count.
REQ-021 In S_DEB_UP, a pressed level SHALL return to S_DOWN with the hold count preserved and no event; a tick at count P_DEBOUNCE_MS-1 SHALL enter S_UP, clear o_key and pulse o_release.
REQ-022 Debounce latency from a clean input edge to the pulse SHALL be 2 sync cycles plus between P_DEBOUNCE_MS-1 and P_DEBOUNCE_MS tick periods, plus 1 register cycle.
REQ-023 All pulse outputs SHALL be registered and high for exactly one clk cycle.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL pulse their bits in the same cycle, with o_key_val high once.
REQ-025 Counter widths SHALL be $clog2-derived from the parameters, and no counter SHALL wrap.

Reset
REQ-026 While rst=1, all FSMs SHALL enter S_UP, all counters SHALL be 0, the synchronisers SHALL load "released", and o_key, o_press, o_release, o_long and o_key_val SHALL be 0.
REQ-027 Reset asserted mid-press SHALL produce no release pulse; a key still held after reset SHALL be treated as a new press and go through full debounce.

Structure
REQ-028 The state encoding and tick-width localparams SHALL reside in shared package key_pkg.
REQ-029 The per-channel FSM and counters SHALL be sub-module key_chan, instantiated P_KEY_NUM times by generate; the tick generator and o_key_val OR SHALL reside in the top level.

Verification (P_TICK_CYCLES=10, P_DEBOUNCE_MS=3, P_LONG_MS=8, P_KEY_NUM=4, P_ACTIVE_LOW=1)
REQ-030 Reset scenario: rst=1 for 2 cycles with i_key=4'hF, then 200 idle cycles -> all outputs 0 throughout.
REQ-031 Clean press scenario: i_key[0] driven 0 and held -> o_press[0] is a single pulse 23..33 cycles later, and o_key[0]=1 from that cycle on.
REQ-032 Bounce scenario: i_key[1] toggled every 5 cycles for 100 cycles, then held 1 -> no pulses on any output; o_key[1] stays 0.
REQ-033 Long-press scenario: i_key[2] held 0 for 150 cycles -> one o_press, one o_long 80 cycles after o_press, then one o_release after release; with a hold of only 50 cycles -> no o_long.
REQ-034 Simultaneous scenario: i_key[0] and i_key[3] fall in the same cycle -> o_press=4'b1001 in one cycle, and o_key_val pulses once.
REQ-035 Reset-mid-press scenario: i_key[0] held, rst pulsed after o_press -> o_key clears, no o_release, and a new o_press 23..33 cycles after rst deasserts.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: per-channel state encoding and counter sizing.
package key_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [1:0] S_UP     = 2'd0;
  localparam logic [1:0] S_DEB_DN = 2'd1;
  localparam logic [1:0] S_DOWN   = 2'd2;
  localparam logic [1:0] S_DEB_UP = 2'd3;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_chan.sv
// One debounced key channel: press/release debounce FSM, hold timer and registered event pulses.
module key_chan
  import key_pkg::*;
#(
  parameter int unsigned P_DEBOUNCE_MS = 20,
  parameter int unsigned P_LONG_MS     = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_in,
  output logic o_key,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic evt_c
);

  localparam int unsigned DEB_W  = cnt_width(P_DEBOUNCE_MS - 1);
  localparam int unsigned HOLD_W = cnt_width(P_LONG_MS);

  logic [STATE_W-1:0] state, state_nxt;
  logic [DEB_W-1:0]   deb_cnt, deb_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic               key_nxt, press_nxt, release_nxt, long_nxt;

  // State, counters and output pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_UP;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      o_key     <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
    end else begin
      state     <= state_nxt;
      deb_cnt   <= deb_nxt;
      hold_cnt  <= hold_nxt;
      o_key     <= key_nxt;
      o_press   <= press_nxt;
      o_release <= release_nxt;
      o_long    <= long_nxt;
    end
  end

  // Next-state and next-output logic; the hold counter stops at P_LONG_MS so o_long fires once.
  always_comb begin
    state_nxt   = state;
    deb_nxt     = deb_cnt;
    hold_nxt    = hold_cnt;
    key_nxt     = o_key;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    case (state)
      S_UP: begin
        if (key_in) begin
          state_nxt = S_DEB_DN;
          deb_nxt   = '0;
        end
      end
      S_DEB_DN: begin
        if (!key_in) begin
          state_nxt = S_UP;
        end else if (tick) begin
          if (deb_cnt == DEB_W'(P_DEBOUNCE_MS - 1)) begin
            state_nxt = S_DOWN;
            key_nxt   = 1'b1;
            press_nxt = 1'b1;
            hold_nxt  = '0;
          end else begin
            deb_nxt = deb_cnt + DEB_W'(1);
          end
        end
      end
      S_DOWN: begin
        if (!key_in) begin
          state_nxt = S_DEB_UP;
          deb_nxt   = '0;
        end else if (tick && (hold_cnt != HOLD_W'(P_LONG_MS))) begin
          hold_nxt = hold_cnt + HOLD_W'(1);
          long_nxt = (hold_nxt == HOLD_W'(P_LONG_MS));
        end
      end
      S_DEB_UP: begin
        // A bounce back to pressed resumes the hold without an event.
        if (key_in) begin
          state_nxt = S_DOWN;
        end else if (tick) begin
          if (deb_cnt == DEB_W'(P_DEBOUNCE_MS - 1)) begin
            state_nxt   = S_UP;
            key_nxt     = 1'b0;
            release_nxt = 1'b1;
          end else begin
            deb_nxt = deb_cnt + DEB_W'(1);
          end
        end
      end
      default: state_nxt = S_UP;
    endcase
  end

  assign evt_c = press_nxt | release_nxt | long_nxt;

endmodule

// File: rtl/key_debounce_n.sv
// Multi-channel key debouncer: pin normalisation, 2-flop sync, shared 1 ms tick and per-channel FSMs.
module key_debounce_n
  import key_pkg::*;
#(
  parameter int unsigned P_SYSTEM_CLK  = 100_000_000,
  parameter int unsigned P_KEY_NUM     = 4,
  parameter int unsigned P_TICK_CYCLES = P_SYSTEM_CLK / 1000,
  parameter int unsigned P_DEBOUNCE_MS = 20,
  parameter int unsigned P_LONG_MS     = 1000,
  parameter bit          P_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [P_KEY_NUM-1:0] i_key,
  output logic [P_KEY_NUM-1:0] o_key,
  output logic [P_KEY_NUM-1:0] o_press,
  output logic [P_KEY_NUM-1:0] o_release,
  output logic [P_KEY_NUM-1:0] o_long,
  output logic                 o_key_val
);

  localparam int unsigned TICK_W = cnt_width(P_TICK_CYCLES - 1);

  logic [P_KEY_NUM-1:0] key_norm, sync_q1, sync_q2, evt_c;
  logic [TICK_W-1:0]    tick_cnt;
  logic                 tick;

  assign key_norm = P_ACTIVE_LOW ? ~i_key : i_key;

  // Two-flop synchroniser; reset value is "released".
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= key_norm;
      sync_q2 <= sync_q1;
    end
  end

  // Shared tick: one cycle high at the terminal count of a 0..P_TICK_CYCLES-1 counter.
  assign tick = (tick_cnt == TICK_W'(P_TICK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  for (genvar g = 0; g < P_KEY_NUM; g++) begin : g_chan
    key_chan #(
      .P_DEBOUNCE_MS(P_DEBOUNCE_MS),
      .P_LONG_MS    (P_LONG_MS)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .key_in   (sync_q2[g]),
      .o_key    (o_key[g]),
      .o_press  (o_press[g]),
      .o_release(o_release[g]),
      .o_long   (o_long[g]),
      .evt_c    (evt_c[g])
    );
  end

  // Registered from the channels' next-cycle events so it aligns with their pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) o_key_val <= 1'b0;
    else     o_key_val <= |evt_c;
  end

endmodule

// File: tb/tb_key_debounce_n.sv
// Directed bench for key_debounce_n with a 10-cycle tick, 3-tick debounce and 8-tick long press.
module tb_key_debounce_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_key = 4'hF;
  logic [3:0] o_key, o_press, o_release, o_long;
  logic       o_key_val;

  int n_checks = 0;
  int n_pass   = 0;

  int np[4], nr[4], nl[4], fp[4], fr[4], fl[4], key_rise[4], key_drop[4];
  int kv_cnt, kv_bad, cyc;
  bit saw_1001;

  always #5 clk = ~clk;

  key_debounce_n #(
    .P_SYSTEM_CLK (10_000),
    .P_KEY_NUM    (4),
    .P_TICK_CYCLES(10),
    .P_DEBOUNCE_MS(3),
    .P_LONG_MS    (8),
    .P_ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_key    (i_key),
    .o_key    (o_key),
    .o_press  (o_press),
    .o_release(o_release),
    .o_long   (o_long),
    .o_key_val(o_key_val)
  );

  task clear_watch();
    for (int i = 0; i < 4; i++) begin
      np[i] = 0; nr[i] = 0; nl[i] = 0;
      fp[i] = -1; fr[i] = -1; fl[i] = -1;
      key_rise[i] = -1; key_drop[i] = -1;
    end
    kv_cnt = 0; kv_bad = 0; cyc = 0; saw_1001 = 1'b0;
  endtask

  // Advance n cycles, recording pulses (count and first cycle) sampled on the falling edge.
  task watch(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cyc++;
      if (o_key_val !== |(o_press | o_release | o_long)) kv_bad++;
      if (o_key_val === 1'b1) kv_cnt++;
      if (o_press === 4'b1001) saw_1001 = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (o_press[i] === 1'b1)   begin np[i]++; if (fp[i] < 0) fp[i] = cyc; end
        if (o_release[i] === 1'b1) begin nr[i]++; if (fr[i] < 0) fr[i] = cyc; end
        if (o_long[i] === 1'b1)    begin nl[i]++; if (fl[i] < 0) fl[i] = cyc; end
        if (o_key[i] === 1'b1 && key_rise[i] < 0) key_rise[i] = cyc;
        if (o_key[i] !== 1'b1 && key_rise[i] >= 0 && key_drop[i] < 0) key_drop[i] = cyc;
      end
    end
  endtask

  function automatic int total_pulses();
    int s = 0;
    for (int i = 0; i < 4; i++) s += np[i] + nr[i] + nl[i];
    return s;
  endfunction

  task test_reset();
    rst = 1'b1; i_key = 4'hF;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({o_key, o_press, o_release, o_long, o_key_val} !== 17'h0)
      $display("FAIL reset_outputs: got %h want 0", {o_key, o_press, o_release, o_long, o_key_val});
    else n_pass++;
    rst = 1'b0;
    clear_watch();
    watch(200);
    n_checks++;
    if (total_pulses() != 0 || kv_cnt != 0)
      $display("FAIL idle_pulses: got %0d pulses %0d key_val want 0 0", total_pulses(), kv_cnt);
    else n_pass++;
    n_checks++;
    if (o_key !== 4'h0 || key_rise[0] >= 0 || key_rise[3] >= 0)
      $display("FAIL idle_key: got o_key=%h want 0", o_key);
    else n_pass++;
  endtask

  task test_clean_press();
    i_key[0] = 1'b0;
    clear_watch();
    watch(40);
    n_checks++;
    if (np[0] != 1) $display("FAIL press_count: got %0d want 1", np[0]);
    else n_pass++;
    n_checks++;
    if (fp[0] < 23 || fp[0] > 33) $display("FAIL press_latency: got %0d want 23..33", fp[0]);
    else n_pass++;
    n_checks++;
    if (key_rise[0] != fp[0] || key_drop[0] >= 0)
      $display("FAIL press_level: got rise %0d drop %0d want rise %0d drop -1", key_rise[0], key_drop[0], fp[0]);
    else n_pass++;
    n_checks++;
    if (kv_bad != 0 || kv_cnt != 1)
      $display("FAIL press_key_val: got bad %0d count %0d want 0 1", kv_bad, kv_cnt);
    else n_pass++;
    i_key[0] = 1'b1;
    clear_watch();
    watch(40);
    n_checks++;
    if (nr[0] != 1 || np[0] != 0) $display("FAIL release_count: got rel %0d press %0d want 1 0", nr[0], np[0]);
    else n_pass++;
    n_checks++;
    if (fr[0] < 23 || fr[0] > 33) $display("FAIL release_latency: got %0d want 23..33", fr[0]);
    else n_pass++;
    n_checks++;
    if (o_key[0] !== 1'b0) $display("FAIL release_level: got %b want 0", o_key[0]);
    else n_pass++;
  endtask

  task test_bounce();
    clear_watch();
    for (int s = 0; s < 20; s++) begin
      i_key[1] = ~i_key[1];
      watch(5);
    end
    i_key[1] = 1'b1;
    watch(50);
    n_checks++;
    if (total_pulses() != 0 || kv_cnt != 0)
      $display("FAIL bounce_pulses: got %0d pulses %0d key_val want 0 0", total_pulses(), kv_cnt);
    else n_pass++;
    n_checks++;
    if (key_rise[1] >= 0) $display("FAIL bounce_level: got o_key[1] high at %0d want never", key_rise[1]);
    else n_pass++;
  endtask

  task test_long_press();
    i_key[2] = 1'b0;
    clear_watch();
    watch(150);
    n_checks++;
    if (np[2] != 1 || nl[2] != 1) $display("FAIL long_counts: got press %0d long %0d want 1 1", np[2], nl[2]);
    else n_pass++;
    n_checks++;
    if (fl[2] - fp[2] != 80) $display("FAIL long_delay: got %0d want 80", fl[2] - fp[2]);
    else n_pass++;
    i_key[2] = 1'b1;
    clear_watch();
    watch(50);
    n_checks++;
    if (nr[2] != 1 || nl[2] != 0 || np[2] != 0)
      $display("FAIL long_release: got rel %0d long %0d press %0d want 1 0 0", nr[2], nl[2], np[2]);
    else n_pass++;
    i_key[2] = 1'b0;
    clear_watch();
    watch(50);
    i_key[2] = 1'b1;
    watch(50);
    n_checks++;
    if (np[2] != 1 || nl[2] != 0 || nr[2] != 1)
      $display("FAIL short_hold: got press %0d long %0d rel %0d want 1 0 1", np[2], nl[2], nr[2]);
    else n_pass++;
  endtask

  task test_simultaneous();
    i_key = 4'b0110;
    clear_watch();
    watch(40);
    n_checks++;
    if (np[0] != 1 || np[3] != 1 || fp[0] != fp[3])
      $display("FAIL simul_press: got p0 %0d@%0d p3 %0d@%0d want 1 1 same cycle", np[0], fp[0], np[3], fp[3]);
    else n_pass++;
    n_checks++;
    if (!saw_1001) $display("FAIL simul_vector: got no o_press=1001 want one");
    else n_pass++;
    n_checks++;
    if (kv_cnt != 1 || kv_bad != 0) $display("FAIL simul_key_val: got count %0d bad %0d want 1 0", kv_cnt, kv_bad);
    else n_pass++;
    i_key = 4'hF;
    clear_watch();
    watch(40);
    n_checks++;
    if (nr[0] != 1 || nr[3] != 1 || fr[0] != fr[3])
      $display("FAIL simul_release: got r0 %0d@%0d r3 %0d@%0d want 1 1 same cycle", nr[0], fr[0], nr[3], fr[3]);
    else n_pass++;
  endtask

  task test_reset_mid_press();
    i_key[0] = 1'b0;
    clear_watch();
    watch(40);
    n_checks++;
    if (np[0] != 1) $display("FAIL rmp_first_press: got %0d want 1", np[0]);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({o_key, o_press, o_release, o_long, o_key_val} !== 17'h0)
      $display("FAIL rmp_reset_outputs: got %h want 0", {o_key, o_press, o_release, o_long, o_key_val});
    else n_pass++;
    rst = 1'b0;
    clear_watch();
    watch(40);
    n_checks++;
    if (nr[0] != 0) $display("FAIL rmp_no_release: got %0d want 0", nr[0]);
    else n_pass++;
    n_checks++;
    if (np[0] != 1 || fp[0] < 23 || fp[0] > 33)
      $display("FAIL rmp_new_press: got %0d@%0d want 1@23..33", np[0], fp[0]);
    else n_pass++;
    i_key[0] = 1'b1;
    clear_watch();
    watch(40);
    n_checks++;
    if (nr[0] != 1) $display("FAIL rmp_final_release: got %0d want 1", nr[0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
